// File: rtl/blinky_multi.sv
// Multi-channel LED blinker: shared prescaler tick, per-channel power-of-two speed select.
// Optional BLINKY_INPUT_SYNC_EN adds 2-flop synchronisers on i_enable and i_speed.
module blinky_multi #(
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned SPEED_BITS = 2,
   parameter int unsigned BASE_DIV   = 2500
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic [CHANNELS-1:0]          i_enable,
   input  logic [CHANNELS*SPEED_BITS-1:0] i_speed,
   output logic [CHANNELS-1:0]          o_led_drive,
   output logic [CHANNELS-1:0]          o_period_done,
   output logic                         o_tick
);

   localparam int unsigned NUM_SPEEDS = 2 ** SPEED_BITS;
   localparam int unsigned CNT_W      = (NUM_SPEEDS > 2) ? NUM_SPEEDS - 1 : 1;
   localparam int unsigned PRE_W      = $clog2(BASE_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);
   localparam logic [CNT_W:0]   LIM_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   logic [CHANNELS-1:0]            enable;
   logic [CHANNELS*SPEED_BITS-1:0] speed;

`ifdef BLINKY_INPUT_SYNC_EN
   logic [CHANNELS-1:0]            enable_meta;
   logic [CHANNELS-1:0]            enable_sync;
   logic [CHANNELS*SPEED_BITS-1:0] speed_meta;
   logic [CHANNELS*SPEED_BITS-1:0] speed_sync;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         enable_meta <= '0;
         enable_sync <= '0;
         speed_meta  <= '0;
         speed_sync  <= '0;
      end else begin
         enable_meta <= i_enable;
         enable_sync <= enable_meta;
         speed_meta  <= i_speed;
         speed_sync  <= speed_meta;
      end
   end

   assign enable = enable_sync;
   assign speed  = speed_sync;
`else
   assign enable = i_enable;
   assign speed  = i_speed;
`endif

   // Free-running prescaler; runs regardless of channel enables.
   logic [PRE_W-1:0] prescale;
   logic             tick;
   logic             tick_q;

   assign tick = (prescale == PRE_LAST);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         prescale <= '0;
         tick_q   <= 1'b0;
      end else begin
         prescale <= tick ? '0 : prescale + PRE_W'(1);
         tick_q   <= tick;
      end
   end

   assign o_tick = tick_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [CNT_W-1:0]      cnt;
      logic [CNT_W-1:0]      cnt_d;
      logic                  level;
      logic                  level_d;
      logic [SPEED_BITS-1:0] speed_act;
      logic [SPEED_BITS-1:0] speed_act_d;
      logic [SPEED_BITS-1:0] speed_req;
      logic                  done;
      logic                  done_d;
      logic [CNT_W:0]        limit;
      logic                  at_end;

      assign speed_req = speed[c*SPEED_BITS +: SPEED_BITS];

      always_comb begin
         limit       = (LIM_ONE << speed_act) - LIM_ONE;
         at_end      = ({1'b0, cnt} == limit);
         cnt_d       = cnt;
         level_d     = level;
         speed_act_d = speed_act;
         done_d      = 1'b0;
         if (!enable[c]) begin
            // Disable wins over tick; speed tracks the input while parked.
            cnt_d       = '0;
            level_d     = 1'b0;
            speed_act_d = speed_req;
         end else if (tick) begin
            if (at_end) begin
               cnt_d   = '0;
               level_d = ~level;
               // Only a falling edge closes a full period, so speed swaps there.
               if (level) begin
                  speed_act_d = speed_req;
                  done_d      = 1'b1;
               end
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end
      end

      always_ff @(posedge i_clock or posedge i_reset) begin
         if (i_reset) begin
            cnt       <= '0;
            level     <= 1'b0;
            speed_act <= '0;
            done      <= 1'b0;
         end else begin
            cnt       <= cnt_d;
            level     <= level_d;
            speed_act <= speed_act_d;
            done      <= done_d;
         end
      end

      assign o_led_drive[c]   = level;
      assign o_period_done[c] = done;
   end

endmodule

// File: tb/tb_blinky_multi.sv
// Directed bench for blinky_multi with CHANNELS=2, SPEED_BITS=2, BASE_DIV=4.
module tb_blinky_multi;

   logic       clk;
   logic       rst;
   logic [1:0] en;
   logic [3:0] spd;
   logic [1:0] led;
   logic [1:0] done;
   logic       tick;
   int         n;
   int         total;
   int         bad;

   blinky_multi #(
      .CHANNELS  (2),
      .SPEED_BITS(2),
      .BASE_DIV  (4)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_enable     (en),
      .i_speed      (spd),
      .o_led_drive  (led),
      .o_period_done(done),
      .o_tick       (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      n++;
      #1;
   endtask

   // Reset between edges, hold channels disabled for one edge so speed loads, then enable.
   task automatic restart(input logic [1:0] en_v, input logic [3:0] spd_v);
      rst = 1'b1;
      en  = 2'b00;
      spd = spd_v;
      #1;
      rst = 1'b0;
      n   = 0;
      cycle();
      en = en_v;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      en    = 2'b00;
      spd   = {2'd3, 2'd0};
      #2;
      check("reset led", 32'(led), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset tick", 32'(tick), 32'd0);
      rst = 1'b0;
      n   = 0;

      // Ch0 speed 0, ch1 speed 3.
      cycle();
      en = 2'b11;
      for (int k = 2; k <= 72; k++) begin
         cycle();
         check($sformatf("s1 tick n=%0d", n), 32'(tick), 32'(n % 4 == 0));
         check($sformatf("s1 led0 n=%0d", n), 32'(led[0]), 32'(n >= 4 && ((n - 4) % 8) < 4));
         check($sformatf("s1 done0 n=%0d", n), 32'(done[0]), 32'(n >= 8 && n % 8 == 0));
         check($sformatf("s2 led1 n=%0d", n), 32'(led[1]), 32'(n >= 32 && ((n - 32) % 64) < 32));
         check($sformatf("s2 done1 n=%0d", n), 32'(done[1]), 32'(n == 64));
      end

      // Ch0 speed 1, change to speed 2 during a low phase.
      restart(2'b01, 4'b0001);
      for (int k = 2; k <= 66; k++) begin
         logic e_led;
         cycle();
         if (n == 18) spd = 4'b0010;
         e_led = (n >= 8 && n < 16) || (n >= 24 && n < 32) || (n >= 48 && n < 64);
         check($sformatf("s3 led0 n=%0d", n), 32'(led[0]), 32'(e_led));
         check($sformatf("s3 done0 n=%0d", n), 32'(done[0]), 32'(n == 16 || n == 32 || n == 64));
         check($sformatf("s3 led1 n=%0d", n), 32'(led[1]), 32'd0);
      end

      // Ch0 speed 0, disabled mid-high for 10 edges, then re-enabled.
      restart(2'b01, 4'b0000);
      for (int k = 2; k <= 31; k++) begin
         logic e_led;
         cycle();
         e_led = (n >= 4 && n < 8) || (n >= 12 && n < 14) || (n >= 24 && n < 28);
         check($sformatf("s4 led0 n=%0d", n), 32'(led[0]), 32'(e_led));
         check($sformatf("s4 done0 n=%0d", n), 32'(done[0]), 32'(n == 8 || n == 28));
         if (n == 13) en = 2'b00;
         if (n == 23) en = 2'b01;
      end

      // Asynchronous reset while LED high and o_tick asserted.
      restart(2'b01, 4'b0000);
      for (int k = 2; k <= 4; k++) cycle();
      check("s5 led0 pre", 32'(led[0]), 32'd1);
      check("s5 tick pre", 32'(tick), 32'd1);
      rst = 1'b1;
      #1;
      check("s5 led async", 32'(led), 32'd0);
      check("s5 tick async", 32'(tick), 32'd0);
      check("s5 done async", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      check("s5 led held", 32'(led), 32'd0);
      rst = 1'b0;
      n   = 0;
      for (int k = 1; k <= 9; k++) begin
         cycle();
         check($sformatf("s5 tick n=%0d", n), 32'(tick), 32'(n == 4 || n == 8));
         check($sformatf("s5 led0 n=%0d", n), 32'(led[0]), 32'(n >= 4 && n < 8));
         check($sformatf("s5 done0 n=%0d", n), 32'(done[0]), 32'(n == 8));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
